// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if: fetch lookup and execute update bus for the branch target predictor.
interface branch_target_predictor_if #(parameter int PC_W = 64);
  logic [PC_W-1:0] lookup_pc;
  logic lookup_hit;
  logic predict_taken;
  logic [PC_W-1:0] predict_pc;
  logic update_en;
  logic [PC_W-1:0] update_pc;
  logic update_taken;
  logic [PC_W-1:0] update_target;
  logic flush;
  modport master(
    output lookup_pc, update_en, update_pc, update_taken, update_target, flush,
    input lookup_hit, predict_taken, predict_pc
  );
  modport slave(
    input lookup_pc, update_en, update_pc, update_taken, update_target, flush,
    output lookup_hit, predict_taken, predict_pc
  );
endinterface

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with per-entry saturating direction counters.
module branch_target_predictor #(
  parameter int PC_W = 64,
  parameter int IDX_W = 5,
  parameter int CNT_W = 2,
  parameter int ALIGN = 2
) (
  input logic clk,
  input logic arst_n,
  branch_target_predictor_if.slave bus
);
  localparam int TAG_W = PC_W - IDX_W - ALIGN;
  localparam int N = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_RST = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_WT = {1'b1, {(CNT_W-1){1'b0}}};
  logic [N-1:0] valid;
  logic [CNT_W-1:0] cnt [N];
  logic [TAG_W-1:0] tag [N];
  logic [PC_W-1:0] target [N];
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic u_hit;
  logic [CNT_W-1:0] u_cnt, u_cnt_next;
  assign l_idx = bus.lookup_pc[ALIGN+IDX_W-1:ALIGN];
  assign l_tag = bus.lookup_pc[PC_W-1:ALIGN+IDX_W];
  assign u_idx = bus.update_pc[ALIGN+IDX_W-1:ALIGN];
  assign u_tag = bus.update_pc[PC_W-1:ALIGN+IDX_W];
  assign bus.lookup_hit = valid[l_idx] && (tag[l_idx] == l_tag);
  assign bus.predict_taken = bus.lookup_hit && cnt[l_idx][CNT_W-1];
  assign bus.predict_pc = bus.predict_taken ? target[l_idx]
                                            : bus.lookup_pc + (PC_W'(1) << ALIGN);
  assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);
  assign u_cnt = cnt[u_idx];
  always_comb begin
    u_cnt_next = CNT_WT;
    if (u_hit)
      u_cnt_next = bus.update_taken ? ((&u_cnt) ? u_cnt : u_cnt + 1'b1)
                                    : ((|u_cnt) ? u_cnt - 1'b1 : u_cnt);
  end
  // Valid bits and counters must come out of reset; tags and targets are qualified by valid.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= CNT_RST;
    end else if (bus.flush) begin
      valid <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= CNT_RST;
    end else if (bus.update_en && (u_hit || bus.update_taken)) begin
      valid[u_idx] <= 1'b1;
      cnt[u_idx] <= u_cnt_next;
    end
  end
  always_ff @(posedge clk) begin
    if (!bus.flush && bus.update_en && bus.update_taken) begin
      tag[u_idx] <= u_tag;
      target[u_idx] <= bus.update_target;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed self-checking bench for the branch target predictor.
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic arst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  branch_target_predictor_if #(.PC_W(64)) bus ();
  branch_target_predictor #(.PC_W(64), .IDX_W(5), .CNT_W(2), .ALIGN(2)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic look(input string name, input logic [63:0] pc, input logic hit,
                      input logic tk, input logic [63:0] npc);
    bus.lookup_pc = pc;
    #1;
    check({name, "_hit"}, 64'(bus.lookup_hit), 64'(hit));
    check({name, "_tk"}, 64'(bus.predict_taken), 64'(tk));
    check({name, "_pc"}, bus.predict_pc, npc);
  endtask
  task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tg);
    bus.update_en = 1'b1;
    bus.update_pc = pc;
    bus.update_taken = tk;
    bus.update_target = tg;
    @(posedge clk);
    #1;
    bus.update_en = 1'b0;
  endtask
  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask
  initial begin
    bus.lookup_pc = 64'h1000;
    bus.update_en = 1'b0;
    bus.update_pc = '0;
    bus.update_taken = 1'b0;
    bus.update_target = '0;
    bus.flush = 1'b0;
    #1 arst_n = 1'b0;
    #10 arst_n = 1'b1;
    @(posedge clk);
    #1;
    look("rst", 64'h1000, 0, 0, 64'h1004);
    look("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0);
    bus.update_en = 1'b1;
    bus.update_pc = 64'h1000;
    bus.update_taken = 1'b1;
    bus.update_target = 64'h2000;
    look("same_cyc", 64'h1000, 0, 0, 64'h1004);
    @(posedge clk);
    #1;
    bus.update_en = 1'b0;
    look("alloc", 64'h1000, 1, 1, 64'h2000);
    upd(64'h1000, 0, 64'h0);
    look("nt1", 64'h1000, 1, 0, 64'h1004);
    upd(64'h1000, 0, 64'h0);
    look("nt2", 64'h1000, 1, 0, 64'h1004);
    upd(64'h1000, 0, 64'h0);
    look("nt_sat", 64'h1000, 1, 0, 64'h1004);
    upd(64'h1000, 1, 64'h2000);
    look("t1", 64'h1000, 1, 0, 64'h1004);
    upd(64'h1000, 1, 64'h2000);
    look("t2", 64'h1000, 1, 1, 64'h2000);
    upd(64'h1000, 1, 64'h2000);
    look("t3", 64'h1000, 1, 1, 64'h2000);
    upd(64'h1000, 1, 64'h3000);
    look("t_sat", 64'h1000, 1, 1, 64'h3000);
    upd(64'h1000, 0, 64'h7777);
    look("sat_nt1", 64'h1000, 1, 1, 64'h3000);
    upd(64'h1000, 0, 64'h7777);
    look("sat_nt2", 64'h1000, 1, 0, 64'h1004);
    do_flush();
    look("flush", 64'h1000, 0, 0, 64'h1004);
    upd(64'h1000, 1, 64'h2000);
    look("alias_a", 64'h1080, 0, 0, 64'h1084);
    upd(64'h1080, 0, 64'h4000);
    look("alias_nt", 64'h1000, 1, 1, 64'h2000);
    upd(64'h1080, 1, 64'h4000);
    look("evicted", 64'h1000, 0, 0, 64'h1004);
    look("evictor", 64'h1080, 1, 1, 64'h4000);
    bus.flush = 1'b1;
    upd(64'h1000, 1, 64'h2000);
    bus.flush = 1'b0;
    look("fl_upd", 64'h1000, 0, 0, 64'h1004);
    look("fl_old", 64'h1080, 0, 0, 64'h1084);
    upd(64'h1000, 1, 64'h2000);
    upd(64'h1000, 1, 64'h2000);
    look("pre_rst", 64'h1000, 1, 1, 64'h2000);
    arst_n = 1'b0;
    #1;
    check("arst_hit", 64'(bus.lookup_hit), 64'h0);
    check("arst_pc", bus.predict_pc, 64'h1004);
    arst_n = 1'b1;
    upd(64'h1000, 1, 64'h5000);
    look("realloc", 64'h1000, 1, 1, 64'h5000);
    upd(64'h1000, 0, 64'h0);
    look("realloc_nt", 64'h1000, 1, 0, 64'h1004);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
